// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the branch-direction predictor.
package branch_predictor_pkg;

  // 2-bit saturating counter states
  localparam logic [1:0] SNT = 2'b00;  // strongly not-taken
  localparam logic [1:0] WNT = 2'b01;  // weakly not-taken
  localparam logic [1:0] WT  = 2'b10;  // weakly taken
  localparam logic [1:0] ST  = 2'b11;  // strongly taken

  // Next counter state after a resolved outcome; saturates at both ends.
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == ST) ? ST : ctr + 2'b01;
    end
    return (ctr == SNT) ? SNT : ctr - 2'b01;
  endfunction

  // Word-aligned table index, zero-extended to 32 bits; caller keeps the low index_bits.
  function automatic logic [31:0] pc_index(input logic [31:0] pc, input int unsigned index_bits);
    return (pc >> 2) & ((32'd1 << index_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/branch_predictor_bht_ram.sv
// Branch history table: 2-bit counters with async read, sync read-modify-write
// training port and a same-index bypass so the reader sees this cycle's update.
module branch_predictor_bht_ram
  import branch_predictor_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 6,
  parameter logic [1:0]  INIT_STATE = WNT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic [1:0]            rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic                  wr_taken
);

  localparam int unsigned Entries = 2 ** INDEX_BITS;

  logic [1:0] mem_q [Entries];
  logic [1:0] wr_next;

  // Trained value for the entry being written, and bypassed read
  always_comb begin
    wr_next = sat_update(mem_q[wr_idx], wr_taken);
    rd_data = (wr_en && (wr_idx == rd_idx)) ? wr_next : mem_q[rd_idx];
  end

  // Counter array: async reset to the initial state, one write per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(Entries); i++) begin
        mem_q[i] <= INIT_STATE;
      end
    end else if (wr_en) begin
      mem_q[wr_idx] <= wr_next;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch-direction predictor: predicts in ID, trains and counts in EX.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 6,
  parameter logic [1:0]  INIT_STATE = WNT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC_Addr_ID,
  input  logic        Branch_ID,
  output logic        BranchPredict_ID,
  input  logic        stall,
  input  logic        Branch_Ex,
  input  logic        BranchPredict_Ex,
  input  logic [31:0] PC_Addr_out_Ex,
  input  logic        Taken_Ex,
  output logic        Mispredict_Ex,
  output logic [31:0] BranchCount,
  output logic [31:0] MispredictCount
);

  logic [31:0]           idx_id_full;
  logic [31:0]           idx_ex_full;
  logic [INDEX_BITS-1:0] idx_id;
  logic [INDEX_BITS-1:0] idx_ex;
  logic [1:0]            ctr_id;
  logic                  upd;
  logic [31:0]           branch_count_q;
  logic [31:0]           mispredict_count_q;
  logic                  unused_idx_bits;

  // Index extraction, update gating and output decode
  always_comb begin
    idx_id_full      = pc_index(PC_Addr_ID, INDEX_BITS);
    idx_ex_full      = pc_index(PC_Addr_out_Ex, INDEX_BITS);
    idx_id           = idx_id_full[INDEX_BITS-1:0];
    idx_ex           = idx_ex_full[INDEX_BITS-1:0];
    // A stalled EX branch is trained and counted only on its unstalled cycle
    upd              = Branch_Ex & ~stall & ~rst;
    BranchPredict_ID = ~rst & Branch_ID & ctr_id[1];
    // Not qualified by stall; the flush logic does that
    Mispredict_Ex    = ~rst & Branch_Ex & (Taken_Ex != BranchPredict_Ex);
  end

  assign unused_idx_bits = ^{idx_id_full[31:INDEX_BITS], idx_ex_full[31:INDEX_BITS]};

  branch_predictor_bht_ram #(
    .INDEX_BITS (INDEX_BITS),
    .INIT_STATE (INIT_STATE)
  ) u_bht_ram (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (idx_id),
    .rd_data  (ctr_id),
    .wr_en    (upd),
    .wr_idx   (idx_ex),
    .wr_taken (Taken_Ex)
  );

  // Performance counters, wrapping modulo 2**32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else if (upd) begin
      branch_count_q <= branch_count_q + 32'd1;
      if (Mispredict_Ex) begin
        mispredict_count_q <= mispredict_count_q + 32'd1;
      end
    end
  end

  assign BranchCount     = branch_count_q;
  assign MispredictCount = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with an integer-arithmetic reference model.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] pc_id;
  logic        br_id;
  logic        pred_id;
  logic        stall;
  logic        br_ex;
  logic        pred_ex;
  logic [31:0] pc_ex;
  logic        taken_ex;
  logic        mis_ex;
  logic [31:0] bcount;
  logic [31:0] mcount;

  int tests_run;
  int tests_failed;

  // Reference model state: counter values 0..3 per entry, plus stats
  int          m_ctr [64];
  logic [31:0] m_bc;
  logic [31:0] m_mc;

  branch_predictor #(
    .INDEX_BITS (6),
    .INIT_STATE (2'b01)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .PC_Addr_ID       (pc_id),
    .Branch_ID        (br_id),
    .BranchPredict_ID (pred_id),
    .stall            (stall),
    .Branch_Ex        (br_ex),
    .BranchPredict_Ex (pred_ex),
    .PC_Addr_out_Ex   (pc_ex),
    .Taken_Ex         (taken_ex),
    .Mispredict_Ex    (mis_ex),
    .BranchCount      (bcount),
    .MispredictCount  (mcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pidx(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'd64);
  endfunction

  function automatic int trained(input int c, input logic t);
    if (t) return (c >= 3) ? 3 : c + 1;
    return (c <= 0) ? 0 : c - 1;
  endfunction

  function automatic logic m_upd();
    return (rst === 1'b0) && (br_ex === 1'b1) && (stall === 1'b0);
  endfunction

  function automatic logic exp_pred();
    int c;
    if (rst !== 1'b0 || br_id !== 1'b1) return 1'b0;
    c = m_ctr[pidx(pc_id)];
    if (m_upd() && pidx(pc_ex) == pidx(pc_id)) c = trained(c, taken_ex);
    return (c >= 2);
  endfunction

  function automatic logic exp_mis();
    if (rst !== 1'b0 || br_ex !== 1'b1) return 1'b0;
    return (taken_ex != pred_ex);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_ctr[i] = 1;
    m_bc = '0;
    m_mc = '0;
  endtask

  // Model's view of a rising edge, taken from the inputs present at that edge
  task automatic model_clock();
    if (m_upd()) begin
      m_bc = m_bc + 32'd1;
      if (exp_mis()) m_mc = m_mc + 32'd1;
      m_ctr[pidx(pc_ex)] = trained(m_ctr[pidx(pc_ex)], taken_ex);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("pred_id", {31'd0, pred_id}, {31'd0, exp_pred()});
    check("mispredict_ex", {31'd0, mis_ex}, {31'd0, exp_mis()});
    check("branch_count", bcount, m_bc);
    check("mispredict_count", mcount, m_mc);
  endtask

  // Called just after a negedge with inputs already driven
  task automatic cycle();
    #1 compare_all();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic drive(input logic bid, input logic [31:0] pid, input logic bex,
                       input logic [31:0] pex, input logic tex, input logic pex_pred,
                       input logic st);
    br_id    = bid;
    pc_id    = pid;
    br_ex    = bex;
    pc_ex    = pex;
    taken_ex = tex;
    pred_ex  = pex_pred;
    stall    = st;
  endtask

  task automatic query(input string name, input logic [31:0] pc, input logic exp);
    drive(1'b1, pc, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1 check(name, {31'd0, pred_id}, {31'd0, exp});
    cycle();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1;
    drive(1'b1, 32'h0040_0010, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    cycle();
    rst = 1'b0;

    // 1: post-reset prediction and stats
    cycle();
    check("t1_pred", {31'd0, pred_id}, 32'd0);
    check("t1_bcount", bcount, 32'd0);
    check("t1_mcount", mcount, 32'd0);

    // 2: train 0x0040_0010 taken twice with prediction 0
    drive(1'b0, 32'h0, 1'b1, 32'h0040_0010, 1'b1, 1'b0, 1'b0);
    #1 check("t2_mis_c1", {31'd0, mis_ex}, 32'd1);
    cycle();
    check("t2_mcount_c1", mcount, 32'd1);
    cycle();
    check("t2_mcount_c2", mcount, 32'd2);
    check("t2_bcount", bcount, 32'd2);
    check("t2_model_ctr", m_ctr[4], 32'd3);
    query("t2_pred", 32'h0040_0010, 1'b1);

    // 3: saturation on 0x0040_0020
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b1, 32'h0040_0020, 1'b1, 1'b0, 1'b0);
      cycle();
    end
    drive(1'b0, 32'h0, 1'b1, 32'h0040_0020, 1'b0, 1'b0, 1'b0);
    cycle();
    query("t3_pred_after_one_nt", 32'h0040_0020, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h0040_0020, 1'b1, 32'h0040_0020, 1'b0, 1'b0, 1'b0);
      cycle();
    end
    check("t3_model_ctr_floor", m_ctr[8], 32'd0);
    // From 00 one taken gives 01 (predict 0); from 01 it would give 10
    drive(1'b0, 32'h0, 1'b1, 32'h0040_0020, 1'b1, 1'b0, 1'b0);
    cycle();
    query("t3_pred_floor", 32'h0040_0020, 1'b0);
    check("t3_bcount", bcount, 32'd12);
    check("t3_mcount", mcount, 32'd7);

    // 4: stall holds EX for three cycles, one update on release
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b1, 32'h0040_0030, 1'b1, 1'b0, 1'b1);
      #1 check("t4_mis_in_stall", {31'd0, mis_ex}, 32'd1);
      cycle();
    end
    check("t4_bcount_stalled", bcount, 32'd12);
    drive(1'b0, 32'h0, 1'b1, 32'h0040_0030, 1'b1, 1'b0, 1'b0);
    cycle();
    check("t4_bcount", bcount, 32'd13);
    check("t4_mcount", mcount, 32'd8);

    // 5: same-cycle bypass, then aliasing of 0x100 onto 0x0
    drive(1'b1, 32'h0040_0040, 1'b1, 32'h0040_0040, 1'b1, 1'b0, 1'b0);
    #1 check("t5_bypass", {31'd0, pred_id}, 32'd1);
    cycle();
    drive(1'b0, 32'h0, 1'b1, 32'h0000_0100, 1'b1, 1'b1, 1'b0);
    cycle();
    query("t5_alias", 32'h0000_0000, 1'b1);
    check("t5_bcount", bcount, 32'd15);
    check("t5_mcount", mcount, 32'd9);

    // 6: drive entry 5 to 11, then reset asynchronously mid-training
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'h0, 1'b1, 32'h0000_0014, 1'b1, 1'b1, 1'b0);
      cycle();
    end
    query("t6_pre_reset", 32'h0000_0014, 1'b1);
    drive(1'b1, 32'h0000_0014, 1'b1, 32'h0000_0014, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    model_reset();
    #1 check("t6_pred_in_reset", {31'd0, pred_id}, 32'd0);
    check("t6_mis_in_reset", {31'd0, mis_ex}, 32'd0);
    check("t6_bcount_in_reset", bcount, 32'd0);
    @(negedge clk);
    cycle();
    rst = 1'b0;
    // Flushed bubble with unknown EX PC and outcome
    drive(1'b1, 32'h0000_0014, 1'b0, 32'hxxxx_xxxx, 1'bx, 1'bx, 1'b0);
    #1 check("t6_pred_after_reset", {31'd0, pred_id}, 32'd0);
    check("t6_mis_bubble", {31'd0, mis_ex}, 32'd0);
    cycle();
    cycle();
    check("t6_bcount", bcount, 32'd0);
    check("t6_mcount", mcount, 32'd0);
    drive(1'b0, 32'h0, 1'b1, 32'h0000_0014, 1'b1, 1'b1, 1'b0);
    cycle();
    query("t6_retrain", 32'h0000_0014, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
